// File: rtl/detector_moore_pkg.sv
// rtl/detector_moore_pkg.sv - state type and width for the 1110 Moore detector
package detector_moore_pkg;

    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        S0 = 3'd0,
        S1 = 3'd1,
        S2 = 3'd2,
        S3 = 3'd3,
        S4 = 3'd4
    } state_t;

endpackage

// File: rtl/detector_moore.sv
// rtl/detector_moore.sv - Moore FSM flagging every (overlapping) 1110 in a serial stream
module detector_moore
    import detector_moore_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic x,
    output logic detected
);

    state_t state_q;
    state_t state_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S0;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = S0;
        case (state_q)
            S0:      state_d = x ? S1 : S0;
            S1:      state_d = x ? S2 : S0;
            S2:      state_d = x ? S3 : S0;
            // Any run of three or more ones parks here until the closing zero.
            S3:      state_d = x ? S3 : S4;
            S4:      state_d = x ? S1 : S0;
            default: state_d = S0;
        endcase
    end

    assign detected = (state_q == S4);

endmodule

// File: tb/tb_detector_moore.sv
// tb/tb_detector_moore.sv - self-checking bench for detector_moore
module tb_detector_moore;

    logic clk;
    logic rst;
    logic x;
    logic detected;

    int checks;
    int errors;

    // Every bit sampled since the last reset, oldest first.
    logic hist[$];

    detector_moore dut (
        .clk      (clk),
        .rst      (rst),
        .x        (x),
        .detected (detected)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    function automatic logic model_detected();
        int n;
        n = hist.size();
        if (n < 4) return 1'b0;
        return hist[n-4] && hist[n-3] && hist[n-2] && !hist[n-1];
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        x   = 1'b0;
        hist.delete();
        repeat (3) @(posedge clk);
        #1;
        check("reset_held", detected, 1'b0);
        rst = 1'b0;
    endtask

    task automatic apply_bit(input logic b, input string tag);
        x = b;
        @(posedge clk);
        #1;
        hist.push_back(b);
        check(tag, detected, model_detected());
    endtask

    task automatic run_seq(input string tag, input logic [15:0] bits, input int n, input int exp_cnt);
        int cnt;
        do_reset();
        cnt = 0;
        for (int i = n - 1; i >= 0; i--) begin
            apply_bit(bits[i], tag);
            if (detected) cnt++;
        end
        apply_bit(1'b0, tag);
        if (detected) cnt++;
        check({tag, "_count"}, cnt, exp_cnt);
    endtask

    initial begin
        int cnt;
        checks = 0;
        errors = 0;
        rst    = 1'b1;
        x      = 1'b0;

        run_seq("p11110",     16'b11110,     5, 1);
        run_seq("p110",       16'b110,       3, 0);
        run_seq("p111110",    16'b111110,    6, 1);
        run_seq("p11011",     16'b11011,     5, 0);
        run_seq("p111011110", 16'b111011110, 9, 2);

        // Reset asserted between edges while detecting must clear the output at once.
        do_reset();
        apply_bit(1'b1, "pre_async");
        apply_bit(1'b1, "pre_async");
        apply_bit(1'b1, "pre_async");
        apply_bit(1'b0, "pre_async");
        check("in_s4_before_async_rst", detected, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_drop", detected, 1'b0);
        do_reset();
        cnt = 0;
        apply_bit(1'b1, "post_async");
        apply_bit(1'b1, "post_async");
        apply_bit(1'b1, "post_async");
        apply_bit(1'b0, "post_async");
        if (detected) cnt++;
        apply_bit(1'b0, "post_async");
        if (detected) cnt++;
        check("post_async_count", cnt, 1);

        // Random stream biased toward ones so long runs and overlaps occur often.
        do_reset();
        for (int i = 0; i < 500; i++) begin
            apply_bit(($urandom % 4) != 0, "random");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
